// File: rtl/psg_mix_pkg.sv
// Shared definitions for the PSG stereo mixer: controller states,
// default widths and the bit positions of the gain fields in a pan byte.
package psg_mix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_FILT = 2'd2,
        ST_PUSH = 2'd3
    } mix_state_e;

    localparam int DEF_DAC_BITS   = 8;
    localparam int DEF_OUT_BITS   = 16;
    localparam int DEF_DC_SHIFT   = 8;
    localparam int DEF_FIFO_DEPTH = 4;

    // Six multiply steps: three channels for the left side, then three for the right
    localparam int MAC_STEPS = 6;

    // Pan byte layout: upper nibble = left gain, lower nibble = right gain
    localparam int GAIN_BITS  = 4;
    localparam int GAIN_L_MSB = 7;
    localparam int GAIN_L_LSB = 4;
    localparam int GAIN_R_MSB = 3;
    localparam int GAIN_R_LSB = 0;

endpackage

// File: rtl/psg_mix_fifo.sv
// Small first-word-fall-through FIFO. The head entry is always visible on
// dout while the FIFO is non-empty. A push into a full FIFO is accepted
// only when a pop happens in the same cycle (the pop frees the slot first).
module psg_mix_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_pop_s, do_push_s;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == {CW{1'b0}});
    assign dout  = mem_q[rd_ptr_q];

    // Next-state of storage, pointers and occupancy
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        do_pop_s  = pop & ~empty;
        do_push_s = push & (~full | do_pop_s);
        if (do_push_s) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO state registers; storage is cleared so the idle head reads zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/psg_stereo_mixer.sv
// Stereo mixer for a three-channel PSG. Each strobed sample is panned into
// left/right sums with one shared multiplier, re-centred either against a
// fixed midpoint or a slow DC tracker, scaled/saturated to the output width
// and queued in an output FIFO with a valid/ready interface.
module psg_stereo_mixer
    import psg_mix_pkg::*;
#(
    parameter int DAC_BITS   = DEF_DAC_BITS,
    parameter int OUT_BITS   = DEF_OUT_BITS,
    parameter int DC_SHIFT   = DEF_DC_SHIFT,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sample_stb,
    input  logic [DAC_BITS-1:0]        ch_a,
    input  logic [DAC_BITS-1:0]        ch_b,
    input  logic [DAC_BITS-1:0]        ch_c,
    input  logic [7:0]                 pan_a,
    input  logic [7:0]                 pan_b,
    input  logic [7:0]                 pan_c,
    input  logic                       dc_en,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [OUT_BITS-1:0] out_left,
    output logic signed [OUT_BITS-1:0] out_right,
    input  logic                       flag_clr,
    output logic                       missed,
    output logic                       overrun,
    output logic                       clip
);

    localparam int W  = DAC_BITS + 6;         // accumulator width, cannot overflow
    localparam int PW = DAC_BITS + GAIN_BITS; // single product width
    localparam int DW = W + DC_SHIFT;         // DC tracker width
    localparam int SH = OUT_BITS - W;         // left shift to the output scale
    localparam int SW = OUT_BITS + 1;         // shifted difference before saturation
    localparam logic [W-1:0]         MID   = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [SW-1:0] MAX_V = {2'b00, {(OUT_BITS-1){1'b1}}};
    localparam logic signed [SW-1:0] MIN_V = {2'b11, {(OUT_BITS-1){1'b0}}};

    if (OUT_BITS < DAC_BITS + 6) begin : g_bad_out_bits
        $error("psg_stereo_mixer: OUT_BITS must be at least DAC_BITS+6");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("psg_stereo_mixer: FIFO_DEPTH must be a power of two >= 2");
    end

    // Re-centre x against r and scale it up to the output range
    function automatic logic signed [SW-1:0] side_diff(input logic [W-1:0] x,
                                                        input logic [W-1:0] r);
        logic signed [SW-1:0] d;
        d = $signed({{(SW-W){1'b0}}, x}) - $signed({{(SW-W){1'b0}}, r});
        return d <<< SH;
    endfunction

    // Saturate to the signed output range; MSB of the result flags clipping
    function automatic logic [OUT_BITS:0] sat_out(input logic signed [SW-1:0] v);
        if (v > MAX_V) begin
            return {1'b1, MAX_V[OUT_BITS-1:0]};
        end else if (v < MIN_V) begin
            return {1'b1, MIN_V[OUT_BITS-1:0]};
        end else begin
            return {1'b0, v[OUT_BITS-1:0]};
        end
    endfunction

    mix_state_e             state_q, state_d;
    logic [2:0]             step_q, step_d;
    logic [DAC_BITS-1:0]    ch_a_q, ch_b_q, ch_c_q, ch_a_d, ch_b_d, ch_c_d;
    logic [7:0]             pan_a_q, pan_b_q, pan_c_q, pan_a_d, pan_b_d, pan_c_d;
    logic                   dc_en_q, dc_en_d;
    logic [W-1:0]           acc_l_q, acc_r_q, acc_l_d, acc_r_d;
    logic [DW-1:0]          dcacc_l_q, dcacc_r_q, dcacc_l_d, dcacc_r_d;
    logic [OUT_BITS-1:0]    res_l_q, res_r_q, res_l_d, res_r_d;
    logic                   missed_q, overrun_q, clip_q, missed_d, overrun_d, clip_d;

    logic                   snap_s, mac_s, filt_s, push_s;
    logic [DAC_BITS-1:0]    ch_sel_s;
    logic [7:0]             pan_sel_s;
    logic [GAIN_BITS-1:0]   gain_s;
    logic [PW-1:0]          prod_s;
    logic                   right_s;
    logic [W-1:0]           ref_l_s, ref_r_s;
    logic [OUT_BITS:0]      sat_l_s, sat_r_s;
    logic                   fifo_full_s, fifo_empty_s, fifo_pop_s;
    logic [2*OUT_BITS-1:0]  fifo_head_s;

    // Controller state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Controller next state: IDLE -> MAC (6 steps) -> FILT -> PUSH -> IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = sample_stb ? ST_MAC : ST_IDLE;
            ST_MAC:  state_d = (step_q == 3'(MAC_STEPS - 1)) ? ST_FILT : ST_MAC;
            ST_FILT: state_d = ST_PUSH;
            ST_PUSH: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Controller outputs: one-hot phase strobes for the datapath
    always_comb begin
        snap_s = 1'b0;
        mac_s  = 1'b0;
        filt_s = 1'b0;
        push_s = 1'b0;
        case (state_q)
            ST_IDLE: snap_s = sample_stb;
            ST_MAC:  mac_s  = 1'b1;
            ST_FILT: filt_s = 1'b1;
            ST_PUSH: push_s = 1'b1;
            default: snap_s = 1'b0;
        endcase
    end

    // Shared multiplier operand select: steps 0..2 left gains, 3..5 right gains
    always_comb begin
        ch_sel_s  = '0;
        pan_sel_s = 8'h00;
        right_s   = (step_q >= 3'd3);
        case (step_q)
            3'd0, 3'd3: begin ch_sel_s = ch_a_q; pan_sel_s = pan_a_q; end
            3'd1, 3'd4: begin ch_sel_s = ch_b_q; pan_sel_s = pan_b_q; end
            3'd2, 3'd5: begin ch_sel_s = ch_c_q; pan_sel_s = pan_c_q; end
            default:    begin ch_sel_s = '0;     pan_sel_s = 8'h00;   end
        endcase
        if (right_s) begin
            gain_s = pan_sel_s[GAIN_R_MSB:GAIN_R_LSB];
        end else begin
            gain_s = pan_sel_s[GAIN_L_MSB:GAIN_L_LSB];
        end
        prod_s = PW'(ch_sel_s) * PW'(gain_s);
    end

    // Filter stage: reference uses the tracker value from before this sample
    always_comb begin
        if (dc_en_q) begin
            ref_l_s = dcacc_l_q[DW-1:DC_SHIFT];
            ref_r_s = dcacc_r_q[DW-1:DC_SHIFT];
        end else begin
            ref_l_s = MID;
            ref_r_s = MID;
        end
        sat_l_s = sat_out(side_diff(acc_l_q, ref_l_s));
        sat_r_s = sat_out(side_diff(acc_r_q, ref_r_s));
    end

    // Datapath next state: snapshot, accumulate, filter and track DC
    always_comb begin
        step_d    = step_q;
        ch_a_d    = ch_a_q;
        ch_b_d    = ch_b_q;
        ch_c_d    = ch_c_q;
        pan_a_d   = pan_a_q;
        pan_b_d   = pan_b_q;
        pan_c_d   = pan_c_q;
        dc_en_d   = dc_en_q;
        acc_l_d   = acc_l_q;
        acc_r_d   = acc_r_q;
        dcacc_l_d = dcacc_l_q;
        dcacc_r_d = dcacc_r_q;
        res_l_d   = res_l_q;
        res_r_d   = res_r_q;
        if (snap_s) begin
            ch_a_d  = ch_a;
            ch_b_d  = ch_b;
            ch_c_d  = ch_c;
            pan_a_d = pan_a;
            pan_b_d = pan_b;
            pan_c_d = pan_c;
            dc_en_d = dc_en;
            acc_l_d = '0;
            acc_r_d = '0;
            step_d  = 3'd0;
        end else if (mac_s) begin
            if (right_s) begin
                acc_r_d = acc_r_q + {{(W-PW){1'b0}}, prod_s};
            end else begin
                acc_l_d = acc_l_q + {{(W-PW){1'b0}}, prod_s};
            end
            step_d = step_q + 3'd1;
        end else if (filt_s) begin
            res_l_d   = sat_l_s[OUT_BITS-1:0];
            res_r_d   = sat_r_s[OUT_BITS-1:0];
            dcacc_l_d = dcacc_l_q + {{DC_SHIFT{1'b0}}, acc_l_q} - (dcacc_l_q >> DC_SHIFT);
            dcacc_r_d = dcacc_r_q + {{DC_SHIFT{1'b0}}, acc_r_q} - (dcacc_r_q >> DC_SHIFT);
        end else begin
            step_d = step_q;
        end
    end

    // Sticky flags: a set event in the same cycle as flag_clr wins
    always_comb begin
        fifo_pop_s = ~fifo_empty_s & out_ready;
        missed_d   = (sample_stb & (state_q != ST_IDLE)) | (missed_q & ~flag_clr);
        overrun_d  = (push_s & fifo_full_s & ~fifo_pop_s) | (overrun_q & ~flag_clr);
        clip_d     = (filt_s & (sat_l_s[OUT_BITS] | sat_r_s[OUT_BITS])) | (clip_q & ~flag_clr);
    end

    // Datapath and flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q    <= 3'd0;
            ch_a_q    <= '0;
            ch_b_q    <= '0;
            ch_c_q    <= '0;
            pan_a_q   <= 8'h00;
            pan_b_q   <= 8'h00;
            pan_c_q   <= 8'h00;
            dc_en_q   <= 1'b0;
            acc_l_q   <= '0;
            acc_r_q   <= '0;
            dcacc_l_q <= '0;
            dcacc_r_q <= '0;
            res_l_q   <= '0;
            res_r_q   <= '0;
            missed_q  <= 1'b0;
            overrun_q <= 1'b0;
            clip_q    <= 1'b0;
        end else begin
            step_q    <= step_d;
            ch_a_q    <= ch_a_d;
            ch_b_q    <= ch_b_d;
            ch_c_q    <= ch_c_d;
            pan_a_q   <= pan_a_d;
            pan_b_q   <= pan_b_d;
            pan_c_q   <= pan_c_d;
            dc_en_q   <= dc_en_d;
            acc_l_q   <= acc_l_d;
            acc_r_q   <= acc_r_d;
            dcacc_l_q <= dcacc_l_d;
            dcacc_r_q <= dcacc_r_d;
            res_l_q   <= res_l_d;
            res_r_q   <= res_r_d;
            missed_q  <= missed_d;
            overrun_q <= overrun_d;
            clip_q    <= clip_d;
        end
    end

    psg_mix_fifo #(
        .WIDTH (2 * OUT_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (fifo_pop_s),
        .din   ({res_l_q, res_r_q}),
        .dout  (fifo_head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign out_valid = ~fifo_empty_s;
    assign out_left  = $signed(fifo_head_s[2*OUT_BITS-1:OUT_BITS]);
    assign out_right = $signed(fifo_head_s[OUT_BITS-1:0]);
    assign missed    = missed_q;
    assign overrun   = overrun_q;
    assign clip      = clip_q;

endmodule

// File: tb/tb_psg_stereo_mixer.sv
// Self-checking bench for psg_stereo_mixer at default parameters
// (DAC_BITS=8, OUT_BITS=16, W=14, DC_SHIFT=8, FIFO_DEPTH=4).
module tb_psg_stereo_mixer;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               sample_stb;
    logic [7:0]         ch_a, ch_b, ch_c;
    logic [7:0]         pan_a, pan_b, pan_c;
    logic               dc_en;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_left, out_right;
    logic               flag_clr;
    logic               missed, overrun, clip;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: DC trackers per side and expected sticky clip
    longint dc_l, dc_r;
    bit     exp_clip;

    typedef struct {
        int a, b, c, pa, pb, pc;
        bit dce;
        int el, er;
    } vec_t;
    vec_t tbl[7];

    psg_stereo_mixer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_stb (sample_stb),
        .ch_a       (ch_a),
        .ch_b       (ch_b),
        .ch_c       (ch_c),
        .pan_a      (pan_a),
        .pan_b      (pan_b),
        .pan_c      (pan_c),
        .dc_en      (dc_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_left   (out_left),
        .out_right  (out_right),
        .flag_clr   (flag_clr),
        .missed     (missed),
        .overrun    (overrun),
        .clip       (clip)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    task automatic model_reset();
        dc_l = 0;
        dc_r = 0;
        exp_clip = 1'b0;
    endtask

    // One side: centre against midpoint or tracker mean, scale x4, clamp to 16 bits
    task automatic model_side(input int x, inout longint acc, input bit dce, output int o);
        int rv, v;
        rv = dce ? int'(acc / 256) : 8192;
        v  = (x - rv) * 4;
        if (v > 32767) begin o = 32767; exp_clip = 1'b1; end
        else if (v < -32768) begin o = -32768; exp_clip = 1'b1; end
        else o = v;
        acc = acc + x - acc / 256;
    endtask

    task automatic model_step(input int a, b, c, pa, pb, pc, input bit dce, output int el, er);
        int xl, xr;
        xl = a * (pa / 16) + b * (pb / 16) + c * (pc / 16);
        xr = a * (pa % 16) + b * (pb % 16) + c * (pc % 16);
        model_side(xl, dc_l, dce, el);
        model_side(xr, dc_r, dce, er);
    endtask

    task automatic set_in(input int a, b, c, pa, pb, pc, input bit dce);
        ch_a = 8'(a); ch_b = 8'(b); ch_c = 8'(c);
        pan_a = 8'(pa); pan_b = 8'(pb); pan_c = 8'(pc);
        dc_en = dce;
    endtask

    task automatic do_reset();
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

    // Called at a negedge with out_ready=1: strobe once, wait for the result
    task automatic run_sample(input int a, b, c, pa, pb, pc, input bit dce,
                              output int gl, output int gr, output int lat);
        set_in(a, b, c, pa, pb, pc, dce);
        sample_stb = 1'b1;
        @(negedge clk);
        sample_stb = 1'b0;
        lat = 1;
        while (!out_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        chk("sample_valid", int'(out_valid), 1);
        gl = int'(out_left);
        gr = int'(out_right);
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gl, gr, lat, el, er, nv, l0, a, b, c, pa, pb, pc;
        bit dce;

        tbl[0] = '{255, 255, 255, 8'hF0, 8'hF0, 8'hF0, 1'b0,  13132, -32768};
        tbl[1] = '{100,   0,   0, 8'hF0, 8'hF0, 8'hF0, 1'b0, -26768, -32768};
        tbl[2] = '{  0,   0,   0, 8'hFF, 8'hFF, 8'hFF, 1'b0, -32768, -32768};
        tbl[3] = '{255, 255, 255, 8'h0F, 8'h0F, 8'h0F, 1'b0, -32768,  13132};
        tbl[4] = '{128,  64,  32, 8'h88, 8'h88, 8'h88, 1'b0, -25600, -25600};
        tbl[5] = '{200,   0,   0, 8'hA5, 8'h00, 8'h00, 1'b0, -24768, -28768};
        tbl[6] = '{255, 255, 255, 8'hFF, 8'hFF, 8'hFF, 1'b0,  13132,  13132};

        rst_n = 1'b0; sample_stb = 1'b0; out_ready = 1'b1; flag_clr = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_left", int'(out_left), 0);
        chk("rst_out_right", int'(out_right), 0);
        chk("rst_flags", int'({missed, overrun, clip}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed fixed-midpoint vectors with latency check
        for (int i = 0; i < 7; i++) begin
            run_sample(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].pa, tbl[i].pb, tbl[i].pc,
                       tbl[i].dce, gl, gr, lat);
            chk($sformatf("vec%0d_latency", i), lat, 9);
            chk($sformatf("vec%0d_left", i), gl, tbl[i].el);
            chk($sformatf("vec%0d_right", i), gr, tbl[i].er);
        end
        chk("vec_clip", int'(clip), 0);
        chk("vec_missed", int'(missed), 0);

        // Randomized samples against the reference model
        do_reset();
        model_reset();
        for (int i = 0; i < 40; i++) begin
            a = int'($urandom_range(0, 255)); b = int'($urandom_range(0, 255));
            c = int'($urandom_range(0, 255));
            pa = int'($urandom_range(0, 255)); pb = int'($urandom_range(0, 255));
            pc = int'($urandom_range(0, 255));
            dce = 1'($urandom_range(0, 1));
            model_step(a, b, c, pa, pb, pc, dce, el, er);
            run_sample(a, b, c, pa, pb, pc, dce, gl, gr, lat);
            chk($sformatf("rnd%0d_left", i), gl, el);
            chk($sformatf("rnd%0d_right", i), gr, er);
        end
        chk("rnd_clip", int'(clip), int'(exp_clip));
        chk("rnd_overrun", int'(overrun), 0);

        // DC tracker convergence from a fresh reset
        do_reset();
        model_reset();
        for (int i = 0; i < 4096; i++) begin
            model_step(255, 255, 255, 8'hF0, 8'hF0, 8'hF0, 1'b1, el, er);
            run_sample(255, 255, 255, 8'hF0, 8'hF0, 8'hF0, 1'b1, gl, gr, lat);
            if (i == 0) begin
                chk("dc_first_left", gl, 32767);
                chk("dc_first_clip", int'(clip), 1);
            end
            chk("dc_left", gl, el);
            chk("dc_right", gr, er);
        end
        chk("dc_settled", int'(gl < 64 && gl > -64), 1);

        // Overrun: five strobes with the sink stalled
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_in(10 * (k + 1), 0, 0, 8'hF0, 8'hF0, 8'hF0, 1'b0);
            sample_stb = 1'b1;
            @(negedge clk);
            sample_stb = 1'b0;
            repeat (9) @(negedge clk);
        end
        repeat (5) @(negedge clk);
        chk("ovr_flag", int'(overrun), 1);
        chk("ovr_missed", int'(missed), 0);
        l0 = int'(out_left);
        @(negedge clk);
        chk("ovr_head_stable", int'(out_left), l0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("ovr_valid%0d", k), int'(out_valid), 1);
            chk($sformatf("ovr_left%0d", k), int'(out_left), (10 * (k + 1) * 15 - 8192) * 4);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        chk("ovr_drained", int'(out_valid), 0);
        flag_clr = 1'b1;
        @(negedge clk);
        flag_clr = 1'b0;
        chk("ovr_cleared", int'(overrun), 0);

        // Strobe while busy: ignored, missed set
        do_reset();
        out_ready = 1'b1;
        set_in(255, 255, 255, 8'hF0, 8'hF0, 8'hF0, 1'b0);
        sample_stb = 1'b1;
        @(negedge clk);
        sample_stb = 1'b0;
        repeat (3) @(negedge clk);
        sample_stb = 1'b1;
        @(negedge clk);
        sample_stb = 1'b0;
        nv = 0;
        for (int i = 0; i < 30; i++) begin
            nv += int'(out_valid);
            @(negedge clk);
        end
        chk("miss_outputs", nv, 1);
        chk("miss_flag", int'(missed), 1);
        flag_clr = 1'b1;
        @(negedge clk);
        flag_clr = 1'b0;
        chk("miss_cleared", int'(missed), 0);

        // flag_clr coincident with a set event leaves the flag set
        sample_stb = 1'b1;
        @(negedge clk);
        sample_stb = 1'b0;
        repeat (2) @(negedge clk);
        sample_stb = 1'b1;
        flag_clr = 1'b1;
        @(negedge clk);
        sample_stb = 1'b0;
        flag_clr = 1'b0;
        chk("miss_clr_coincident", int'(missed), 1);
        repeat (20) @(negedge clk);

        // Reset mid-computation: nothing is pushed, everything cleared
        sample_stb = 1'b1;
        @(negedge clk);
        sample_stb = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        nv = 0;
        for (int i = 0; i < 20; i++) begin
            nv += int'(out_valid);
            @(negedge clk);
        end
        chk("abort_outputs", nv, 0);
        chk("abort_flags", int'({missed, overrun, clip}), 0);
        chk("abort_out_left", int'(out_left), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/psg_stereo_mixer.md
PSG_STEREO_MIXER -- requirements
Module: psg_stereo_mixer

Interface
REQ-001 SHALL have parameter DAC_BITS, default 8: width of each PSG channel input (8..14).
REQ-002 SHALL have parameter OUT_BITS, default 16: signed output sample width; elaboration error if OUT_BITS < DAC_BITS+6.
REQ-003 SHALL have parameter DC_SHIFT, default 8: DC-tracker time constant, 2^DC_SHIFT samples.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: output FIFO entries, power of two.
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 sample_stb  in  1  one-cycle strobe marking valid ch_a/ch_b/ch_c (PSG sample output).
REQ-008 ch_a, ch_b, ch_c  in  DAC_BITS each  unsigned linear channel levels.
REQ-009 pan_a, pan_b, pan_c  in  8 each  [7:4] left gain 0..15, [3:0] right gain 0..15.
REQ-010 dc_en  in  1  1 = DC-removal output, 0 = fixed-midpoint output.
REQ-011 out_valid  out  1; out_ready  in  1; valid/ready stream handshake.
REQ-012 out_left, out_right  out  OUT_BITS each  signed samples, FIFO head.
REQ-013 flag_clr  in  1  one-cycle clear of all sticky flags.
REQ-014 missed, overrun, clip  out  1 each  sticky status flags.

Function
REQ-015 FSM states IDLE, MAC, FILT, PUSH; only IDLE accepts sample_stb.
REQ-016 sample_stb in IDLE (cycle 0): snapshot ch_*, pan_*, dc_en; clear both accumulators; go MAC.
REQ-017 MAC: 6 cycles (1..6), one shared multiplier, order A*L, B*L, C*L, A*R, B*R, C*R; unsigned accumulators W = DAC_BITS+6 bits, no overflow possible.
REQ-018 FILT (cycle 7): per side compute d = x - avg_int (dc_en=1) or d = x - 2^(W-1) (dc_en=0), using pre-update avg; then update tracker.
REQ-019 Tracker per side: dc_acc (W+DC_SHIFT bits, unsigned) <= dc_acc + x - (dc_acc >> DC_SHIFT); avg_int = dc_acc >> DC_SHIFT; updates every sample regardless of dc_en.
REQ-020 Output = d << (OUT_BITS-W), saturated to [-2^(OUT_BITS-1), 2^(OUT_BITS-1)-1]; any saturation sets clip.
REQ-021 PUSH (cycle 8): write {left,right} to FIFO; return IDLE; out_valid earliest in cycle 9 (latency 9 clk).
REQ-022 PUSH with FIFO full: sample dropped, FIFO unchanged, overrun set.
REQ-023 sample_stb in MAC/FILT/PUSH: ignored, missed set.
REQ-024 FIFO: first-word-fall-through; pop when out_valid & out_ready; simultaneous push and pop when full: pop then push, no drop.
REQ-025 out_left/out_right stable while out_valid & ~out_ready.
REQ-026 flag_clr coincident with a set event: flag remains set.

Reset
REQ-027 rst_n low: state IDLE, accumulators 0, dc_acc 0, FIFO empty, out_valid 0, out_left/out_right 0, missed/overrun/clip 0.
REQ-028 Reset mid-operation aborts computation; no partial sample is ever pushed.

Structure
REQ-029 Package psg_mix_pkg SHALL hold state enum, default widths, and gain-field index constants.
REQ-030 FIFO SHALL be sub-module psg_mix_fifo (parametric width/depth, full/empty, FWFT).
REQ-031 Target 150-300 lines RTL total.

Verification (DAC_BITS=8, OUT_BITS=16, W=14)
REQ-032 dc_en=0, ch_a=ch_b=ch_c=255, pans 8'hF0, out_ready=1 -> out_left=13132, out_right=-32768, out_valid 9 clk after stb, clip=0.
REQ-033 dc_en=0, ch_a=100, ch_b=ch_c=0, pan_a=8'hF0 -> out_left=-26768, out_right=-32768.
REQ-034 dc_en=1, fresh reset, constant x_left=11475 -> first out_left=32767 with clip=1; after 4096 samples |out_left|<64.
REQ-035 out_ready=0, 5 strobes spaced 10 clk -> 4 entries held in order, 5th dropped, overrun=1; flag_clr -> overrun=0.
REQ-036 stb at cycle 0 and cycle 4 -> one output only, missed=1; rst_n pulse in cycle 5 -> no output, all flags 0, out_valid 0.
